// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer
//   Multi-cycle sequencer for load-multiple / store-multiple at the memory-access stage.
//   Walks the register mask lowest-bit-first, one register per cycle, with contiguous
//   addresses starting at BaseAddr. Passes the pipeline controls through while not transferring.
//
// Ports
//   clk, reset                  clock, asynchronous active-low reset
//   Start, IsStore              instruction valid / 1 = SM, 0 = LM (sampled with Start)
//   RegMask, BaseAddr           register mask and starting address (sampled with Start)
//   Flush                       aborts a transfer in progress, blocks a Start in idle
//   PipeRASelect/WASelect/WriteMem  normal-instruction controls, passed through when not in XFER
//   RASelect, WASelect, WriteMem    controls to the memory-access stage
//   AddrOut                     address on the RAFromPipe path
//   RegIndex, RegWrite          register-file index and LM writeback strobe
//   Stall, Done                 upstream freeze / one-cycle completion pulse
module lm_sm_sequencer #(
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 16
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     Start,
  input  logic                                     IsStore,
  input  logic [NREG-1:0]                          RegMask,
  input  logic [AW-1:0]                            BaseAddr,
  input  logic                                     Flush,
  input  logic                                     PipeRASelect,
  input  logic                                     PipeWASelect,
  input  logic                                     PipeWriteMem,
  output logic                                     RASelect,
  output logic                                     WASelect,
  output logic                                     WriteMem,
  output logic [AW-1:0]                            AddrOut,
  output logic [((NREG > 1) ? $clog2(NREG) : 1)-1:0] RegIndex,
  output logic                                     RegWrite,
  output logic                                     Stall,
  output logic                                     Done
);

  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {StIdle, StXfer, StDone} state_e;

  state_e          stateQ;
  logic [NREG-1:0] maskQ;
  logic [AW-1:0]   addrQ;
  logic            isStoreQ;

  logic [NREG-1:0] lowBit;
  logic [NREG-1:0] maskNext;
  logic [IW-1:0]   lowIdx;

  // Isolate the lowest set bit (two's-complement trick) and encode its position.
  always_comb begin
    lowBit   = maskQ & (~maskQ + {{(NREG-1){1'b0}}, 1'b1});
    maskNext = maskQ & ~lowBit;
    lowIdx   = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (maskQ[i]) lowIdx = IW'(i);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ   <= StIdle;
      maskQ    <= '0;
      addrQ    <= '0;
      isStoreQ <= 1'b0;
    end else begin
      unique case (stateQ)
        StIdle: begin
          if (Start && !Flush) begin
            if (|RegMask) begin
              maskQ    <= RegMask;
              addrQ    <= BaseAddr;
              isStoreQ <= IsStore;
              stateQ   <= StXfer;
            end else begin
              stateQ <= StDone;
            end
          end
        end
        StXfer: begin
          if (Flush) begin
            maskQ  <= '0;
            stateQ <= StIdle;
          end else begin
            maskQ <= maskNext;
            // Address advances per transferred register, wrapping modulo 2^AW.
            addrQ <= addrQ + AW'(1);
            if (maskNext == '0) stateQ <= StDone;
          end
        end
        StDone:  stateQ <= StIdle;
        default: stateQ <= StIdle;
      endcase
    end
  end

  // Outputs are combinational from registered state so reset takes effect without a clock.
  always_comb begin
    RASelect = PipeRASelect;
    WASelect = PipeWASelect;
    WriteMem = PipeWriteMem;
    RegWrite = 1'b0;
    Stall    = 1'b0;
    Done     = 1'b0;
    AddrOut  = addrQ;
    RegIndex = lowIdx;
    unique case (stateQ)
      StIdle: Stall = Start;
      StXfer: begin
        RASelect = 1'b0;
        WASelect = 1'b0;
        WriteMem = isStoreQ & ~Flush;
        RegWrite = ~isStoreQ & ~Flush;
        Stall    = 1'b1;
      end
      StDone:  Done = 1'b1;
      default: Stall = Start;
    endcase
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
module tb_lm_sm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start, IsStore, Flush;
  logic [7:0]  RegMask;
  logic [15:0] BaseAddr;
  logic        PipeRASelect, PipeWASelect, PipeWriteMem;
  logic        RASelect, WASelect, WriteMem;
  logic [15:0] AddrOut;
  logic [2:0]  RegIndex;
  logic        RegWrite, Stall, Done;

  int tests = 0;
  int fails = 0;

  lm_sm_sequencer #(.NREG(8), .AW(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .Start        (Start),
    .IsStore      (IsStore),
    .RegMask      (RegMask),
    .BaseAddr     (BaseAddr),
    .Flush        (Flush),
    .PipeRASelect (PipeRASelect),
    .PipeWASelect (PipeWASelect),
    .PipeWriteMem (PipeWriteMem),
    .RASelect     (RASelect),
    .WASelect     (WASelect),
    .WriteMem     (WriteMem),
    .AddrOut      (AddrOut),
    .RegIndex     (RegIndex),
    .RegWrite     (RegWrite),
    .Stall        (Stall),
    .Done         (Done)
  );

  always #5 clk = ~clk;

  // Control vector order: {RASelect, WASelect, WriteMem, RegWrite, Stall, Done}
  task automatic chkCtl(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    obs = {RASelect, WASelect, WriteMem, RegWrite, Stall, Done};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s ctl got %b want %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chkXfer(input string tag, input logic [2:0] eIdx, input logic [15:0] eAddr);
    logic [18:0] obs;
    obs = {RegIndex, AddrOut};
    tests++;
    assert (obs === {eIdx, eAddr}) else begin
      fails++;
      $error("FAIL %s idx/addr got %0d/%h want %0d/%h (t=%0t)", tag, RegIndex, AddrOut,
             eIdx, eAddr, $time);
    end
  endtask

  task automatic randPipe();
    PipeRASelect = 1'($urandom);
    PipeWASelect = 1'($urandom);
    PipeWriteMem = 1'($urandom);
  endtask

  // Reference: the transfer list is the set bits of the mask in ascending order;
  // the j-th transferred register uses base + j (mod 2^16). Done follows the last one.
  task automatic runTxn(input logic st, input logic [7:0] m, input logic [15:0] b,
                        input int flushAt);
    int   q[$];
    int   k;
    bit   flushed;
    logic [15:0] a;
    for (int i = 0; i < 8; i++) if (m[i]) q.push_back(i);
    k = q.size();
    flushed = 0;
    @(posedge clk); #1;
    Start = 1'b1; IsStore = st; RegMask = m; BaseAddr = b; Flush = 1'b0; randPipe();
    #3 chkCtl("start", {PipeRASelect, PipeWASelect, PipeWriteMem, 1'b0, 1'b1, 1'b0});
    for (int j = 1; j <= k; j++) begin
      @(posedge clk); #1;
      Start = 1'($urandom); IsStore = 1'($urandom); RegMask = 8'($urandom);
      BaseAddr = 16'($urandom); Flush = (j == flushAt); randPipe();
      #3;
      a = b + 16'(j - 1);
      chkCtl("xfer", {1'b0, 1'b0, st & ~Flush, ~st & ~Flush, 1'b1, 1'b0});
      chkXfer("xfer", 3'(q[j-1]), a);
      if (j == flushAt) begin
        flushed = 1;
        break;
      end
    end
    if (!flushed) begin
      @(posedge clk); #1;
      Start = 1'($urandom); Flush = 1'($urandom); randPipe();
      #3 chkCtl("done", {PipeRASelect, PipeWASelect, PipeWriteMem, 1'b0, 1'b0, 1'b1});
    end
    @(posedge clk); #1;
    Start = 1'b0; Flush = 1'($urandom); randPipe();
    #3 chkCtl("idle", {PipeRASelect, PipeWASelect, PipeWriteMem, 1'b0, 1'b0, 1'b0});
  endtask

  initial begin
    reset = 1'b0; Start = 1'b0; IsStore = 1'b0; Flush = 1'b0;
    RegMask = '0; BaseAddr = '0;
    PipeRASelect = 1'b1; PipeWASelect = 1'b0; PipeWriteMem = 1'b1;
    #3;
    chkCtl("reset", 6'b101_000);
    chkXfer("reset", 3'd0, 16'h0000);
    Start = 1'b1;
    #1 chkCtl("reset_stall", 6'b101_010);
    Start = 1'b0;
    @(posedge clk); #1 reset = 1'b1;

    // Idle pass-through
    @(posedge clk); #1;
    PipeRASelect = 1'b1; PipeWASelect = 1'b0; PipeWriteMem = 1'b1;
    #3 chkCtl("pass", 6'b101_000);

    runTxn(1'b1, 8'h05, 16'h0100, 0);   // SM two registers
    runTxn(1'b0, 8'hFF, 16'hFFFE, 0);   // LM all, address wrap
    runTxn(1'b1, 8'h00, 16'h1234, 0);   // empty mask
    runTxn(1'b1, 8'h0F, 16'h2000, 2);   // flush in cycle 2
    runTxn(1'b0, 8'h81, 16'h0300, 0);   // contiguous addresses for sparse mask

    // Flush together with Start in idle: Start ignored
    @(posedge clk); #1;
    Start = 1'b1; Flush = 1'b1; RegMask = 8'hFF; IsStore = 1'b1; randPipe();
    #3 chkCtl("flush_start", {PipeRASelect, PipeWASelect, PipeWriteMem, 1'b0, 1'b1, 1'b0});
    @(posedge clk); #1;
    Start = 1'b0; Flush = 1'b0; randPipe();
    #3 chkCtl("flush_start_nxt", {PipeRASelect, PipeWASelect, PipeWriteMem, 1'b0, 1'b0, 1'b0});

    // Reset mid-LM, cycle 3 of 6
    @(posedge clk); #1;
    Start = 1'b1; IsStore = 1'b0; RegMask = 8'h3F; BaseAddr = 16'h0500; Flush = 1'b0;
    for (int j = 1; j <= 2; j++) begin
      @(posedge clk); #1;
      Start = 1'b0; randPipe();
      #3 chkCtl("rst_lm", 6'b000_110);
      chkXfer("rst_lm", 3'(j - 1), 16'h0500 + 16'(j - 1));
    end
    @(posedge clk); #1;
    Start = 1'b1; randPipe(); reset = 1'b0;
    #1 chkCtl("rst_mid", {PipeRASelect, PipeWASelect, PipeWriteMem, 1'b0, 1'b1, 1'b0});
    chkXfer("rst_mid", 3'd0, 16'h0000);
    Start = 1'b0;
    #1 chkCtl("rst_mid_s0", {PipeRASelect, PipeWASelect, PipeWriteMem, 1'b0, 1'b0, 1'b0});
    @(posedge clk); #1 reset = 1'b1;
    runTxn(1'b0, 8'h80, 16'h0040, 0);

    // Randomized transactions
    for (int n = 0; n < 40; n++) begin
      logic [7:0]  m;
      logic [15:0] b;
      logic        st;
      int          fa;
      m  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      b  = 16'($urandom);
      st = 1'($urandom);
      fa = 0;
      if (m != 0 && $urandom_range(0, 3) == 0) fa = $urandom_range(1, $countones(m));
      runTxn(st, m, b, fa);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lm_sm_sequencer.md
# lm_sm_sequencer

Multi-cycle sequencer for load-multiple (LM) and store-multiple (SM) instructions at the memory-access stage. It takes the register mask and base address, then steps the data memory one register per cycle. During each step it drives the memory-access read/write address selects, the write strobe and the address fed to the RAFromPipe path. It also supplies the register-file index and writeback strobe, and stalls upstream stages until the transfer completes. When idle it passes the pipeline's own select and write controls straight through to the memory-access stage.

## Interface
Parameters:
- NREG, 8, number of architectural registers; the mask is NREG bits wide and RegIndex is log2(NREG) bits wide.
- AW, 16, address/data width.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- Start  in  1  LM/SM instruction is valid in the stage this cycle.
- IsStore  in  1  1 = SM, 0 = LM; sampled with Start.
- RegMask  in  NREG  bit i set means register Ri is transferred; sampled with Start.
- BaseAddr  in  AW  starting memory address from RA; sampled with Start.
- Flush  in  1  synchronous pipeline flush; aborts any sequence in progress.
- PipeRASelect, PipeWASelect, PipeWriteMem  in  1 each  normal-instruction controls, passed through when idle.
- RASelect, WASelect  out  1 each  address-select controls to the memory-access stage.
- WriteMem  out  1  data memory write strobe.
- AddrOut  out  AW  address presented on RAFromPipe.
- RegIndex  out  log2(NREG)  register read (SM) or written (LM) this step.
- RegWrite  out  1  register-file writeback strobe for LM data (MemData).
- Stall  out  1  freeze the PC and the IF/ID/EX registers.
- Done  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, XFER, DONE.
- Internal registers: state, pending mask (NREG), address (AW), IsStore latch.
- IDLE:
  - RASelect, WASelect and WriteMem equal the Pipe* inputs; RegWrite=0; Done=0; Stall=Start.
  - Start=1 with mask≠0: latch mask, BaseAddr and IsStore; go to XFER.
  - Start=1 with mask=0: go to DONE; no memory or register access.
- XFER (one register per cycle):
  - RegIndex = index of the lowest set bit of the pending mask.
  - AddrOut = address register; RASelect=WASelect=0.
  - SM: WriteMem=1, RegWrite=0. LM: WriteMem=0, RegWrite=1 (MemData is combinational in the same cycle).
  - At the clock edge: clear that bit and increment the address by 1, modulo 2^AW (0xFFFF wraps to 0x0000).
  - If the mask is now empty, go to DONE; otherwise stay in XFER.
  - Stall=1; Pipe* inputs are ignored.
- Addresses are contiguous per transferred register, not per mask bit position. Example: mask 0b1000_0001 uses BaseAddr for R0 and BaseAddr+1 for R7.
- DONE: Done=1, Stall=0, controls as in IDLE (pass-through); go to IDLE next cycle.
- Start while in XFER or DONE is ignored.
- Flush=1 in XFER:
  - WriteMem and RegWrite are forced to 0 that cycle.
  - Next state is IDLE, with no Done pulse.
- Flush=1 in IDLE together with Start: the Start is ignored.
- Flush in DONE has no effect; Done still pulses.
- Reset (asynchronous, active-low):
  - state=IDLE, pending mask=0, address=0, IsStore latch=0.
  - AddrOut=0, RegIndex=0, RegWrite=0, Done=0.
  - RASelect, WASelect and WriteMem follow the Pipe* inputs; Stall=Start.
- Reset asserted mid-XFER aborts immediately; outputs take their reset values without waiting for a clock edge.

## Timing
- Start sampled at edge 0 with k set bits: XFER during cycles 1..k, Done in cycle k+1.
- Stall is high from the Start cycle through cycle k, and low in the Done cycle.
- Mask=0: Done in cycle 1; Stall high only in the Start cycle.
- A new Start is accepted in the Done cycle+1 at the earliest.
- Outputs are combinational from registered state plus the Pipe*, Start and Flush inputs; there are no combinational paths from RegMask or BaseAddr.

## Test plan
- SM, mask 0x05, BaseAddr 0x0100: cycle 1 writes R0 at 0x0100; cycle 2 writes R2 at 0x0101; Done in cycle 3; WriteMem=1 only in cycles 1–2; RASelect=WASelect=0.
- LM, mask 0xFF, BaseAddr 0xFFFE: RegWrite in cycles 1–8 with RegIndex 0..7; addresses 0xFFFE, 0xFFFF, 0x0000..0x0005; Done in cycle 9.
- Start with mask 0x00: no WriteMem or RegWrite; Done in cycle 1; Stall high only in the Start cycle.
- SM, mask 0x0F, Flush in cycle 2: exactly one write (R0); WriteMem=0 in cycle 2; IDLE in cycle 3; no Done pulse.
- Idle pass-through with PipeRASelect=1, PipeWASelect=0, PipeWriteMem=1: outputs mirror the inputs. Start asserted in XFER is ignored: transfer count unchanged.
- reset driven low mid-LM (cycle 3 of 6): RegWrite=0, AddrOut=0, Stall=Start immediately. After release, a new Start with mask 0x80 at 0x0040 writes R7 once.
